spmv_lane_mac: RTL

Four-lane multiply-accumulate stage directly downstream of the value fetcher in the sparse accelerator. Each lane pops 8-bit nonzero values from the fetcher's per-lane FIFO and, in lockstep, matching 8-bit vector operands from the vector fetcher. It accumulates `row_len` signed products per lane and presents one accumulated row result per lane with a valid/ready handshake.

---
 rtl/spmv_pkg.sv | 21 ++
 rtl/spmv_lane_mac_if.sv | 47 ++++
 rtl/spmv_mac_lane.sv | 143 ++++++++++++++
 rtl/spmv_lane_mac.sv | 66 ++++++
 4 files changed

// File: rtl/spmv_pkg.sv
// Shared definitions for the sparse accelerator's lane multiply-accumulate
// stage: default widths, the per-lane state encoding and lane slice helpers.
package spmv_pkg;

    localparam int DEF_LANES = 4;   // independent lanes
    localparam int DEF_DW    = 8;   // value/operand width (signed)
    localparam int DEF_AW    = 24;  // accumulator/result width (signed)
    localparam int DEF_LW    = 8;   // row length width

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } lane_state_e;

    // Lowest bit of lane 'lane' inside a bus packed as LANES slices of 'width'.
    function automatic int lane_lsb(input int lane, input int width);
        return lane * width;
    endfunction

endpackage

// File: rtl/spmv_lane_mac_if.sv
// Bus between the value/vector fetchers, the lane MAC stage and the result
// consumer. The sat_flag member exists only when SPMV_MAC_SATURATE_EN is
// defined.
interface spmv_lane_mac_if #(
    parameter int LANES = spmv_pkg::DEF_LANES,
    parameter int DW    = spmv_pkg::DEF_DW,
    parameter int AW    = spmv_pkg::DEF_AW,
    parameter int LW    = spmv_pkg::DEF_LW
) ();

    logic                start;
    logic [LW-1:0]       row_len;
    logic [LANES*DW-1:0] val_in;
    logic [LANES-1:0]    val_empty;
    logic [LANES-1:0]    val_read;
    logic [LANES*DW-1:0] vec_in;
    logic [LANES-1:0]    vec_empty;
    logic [LANES-1:0]    vec_read;
    logic [LANES*AW-1:0] result;
    logic [LANES-1:0]    result_valid;
    logic [LANES-1:0]    result_ready;
    logic                busy;
`ifdef SPMV_MAC_SATURATE_EN
    logic [LANES-1:0]    sat_flag;

    modport master (
        output start, row_len, val_in, val_empty, vec_in, vec_empty, result_ready,
        input  val_read, vec_read, result, result_valid, busy, sat_flag
    );

    modport slave (
        input  start, row_len, val_in, val_empty, vec_in, vec_empty, result_ready,
        output val_read, vec_read, result, result_valid, busy, sat_flag
    );
`else
    modport master (
        output start, row_len, val_in, val_empty, vec_in, vec_empty, result_ready,
        input  val_read, vec_read, result, result_valid, busy
    );

    modport slave (
        input  start, row_len, val_in, val_empty, vec_in, vec_empty, result_ready,
        output val_read, vec_read, result, result_valid, busy
    );
`endif

endinterface

// File: rtl/spmv_mac_lane.sv
// One MAC lane: pops value/operand pairs from two FWFT FIFOs, registers the
// signed product, then folds it into the accumulator one cycle later.
// SPMV_MAC_SATURATE_EN: clamp the accumulator and keep a sticky overflow bit.
module spmv_mac_lane
    import spmv_pkg::*;
#(
    parameter int DW = DEF_DW,
    parameter int AW = DEF_AW,
    parameter int LW = DEF_LW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start_go,
    input  logic [LW-1:0] row_len,
    input  logic [DW-1:0] val,
    input  logic          val_empty,
    input  logic [DW-1:0] vec,
    input  logic          vec_empty,
    output logic          rd,
    output logic [AW-1:0] result,
    output logic          result_valid,
    input  logic          result_ready,
`ifdef SPMV_MAC_SATURATE_EN
    output logic          sat_flag,
`endif
    output logic          busy
);

    localparam int PW = 2 * DW;

    lane_state_e state_reg, state_next;
    logic [LW-1:0] cnt_reg, cnt_next;
    logic [PW-1:0] p_reg, p_next;
    logic          p_valid_reg, p_valid_next;
    logic [AW-1:0] acc_reg, acc_next;

    logic signed [DW-1:0] val_s, vec_s;
    logic signed [PW-1:0] prod;
    logic [AW-1:0]        p_ext;
    logic [AW-1:0]        acc_add;

    assign val_s = val;
    assign vec_s = vec;
    assign prod  = val_s * vec_s;
    assign p_ext = {{(AW-PW){p_reg[PW-1]}}, p_reg};

`ifdef SPMV_MAC_SATURATE_EN
    logic          sat_reg, sat_next;
    logic [AW:0]   sum_wide;
    logic          ovf;

    // One guard bit exposes overflow; clamp towards the sign of the true sum.
    assign sum_wide = {acc_reg[AW-1], acc_reg} + {p_ext[AW-1], p_ext};
    assign ovf      = sum_wide[AW] ^ sum_wide[AW-1];
    assign acc_add  = !ovf ? sum_wide[AW-1:0] :
                      (sum_wide[AW] ? {1'b1, {(AW-1){1'b0}}} : {1'b0, {(AW-1){1'b1}}});
    assign sat_flag = sat_reg;
`else
    assign acc_add  = acc_reg + p_ext;
`endif

    assign result       = acc_reg;
    assign result_valid = (state_reg == DONE);
    assign busy         = (state_reg != IDLE);

    // Next-state, pop strobe and datapath updates for the lane.
    always_comb begin
        state_next   = state_reg;
        cnt_next     = cnt_reg;
        p_next       = p_reg;
        p_valid_next = p_valid_reg;
        acc_next     = acc_reg;
        rd           = 1'b0;
`ifdef SPMV_MAC_SATURATE_EN
        sat_next     = sat_reg;
`endif
        case (state_reg)
            IDLE: begin
                if (start_go) begin
                    cnt_next     = row_len;
                    acc_next     = '0;
                    p_valid_next = 1'b0;
`ifdef SPMV_MAC_SATURATE_EN
                    sat_next     = 1'b0;
`endif
                    state_next   = (row_len == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                rd = (cnt_reg != '0) && !val_empty && !vec_empty;
                if (p_valid_reg) begin
                    acc_next = acc_add;
`ifdef SPMV_MAC_SATURATE_EN
                    if (ovf) begin
                        sat_next = 1'b1;
                    end
`endif
                end
                if (rd) begin
                    p_next       = prod;
                    p_valid_next = 1'b1;
                    cnt_next     = cnt_reg - LW'(1);
                end else begin
                    p_valid_next = 1'b0;
                end
                // The last product is being folded in and nothing is left to read.
                if (p_valid_reg && (cnt_reg == '0)) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (result_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Lane state registers; reset may arrive at any point of a row.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg   <= IDLE;
            cnt_reg     <= '0;
            p_reg       <= '0;
            p_valid_reg <= 1'b0;
            acc_reg     <= '0;
`ifdef SPMV_MAC_SATURATE_EN
            sat_reg     <= 1'b0;
`endif
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            p_reg       <= p_next;
            p_valid_reg <= p_valid_next;
            acc_reg     <= acc_next;
`ifdef SPMV_MAC_SATURATE_EN
            sat_reg     <= sat_next;
`endif
        end
    end

endmodule

// File: rtl/spmv_lane_mac.sv
// Four-lane MAC stage behind the value fetcher. Lanes share start/row_len
// but run independently; busy is the OR of all lanes being out of IDLE.
// SPMV_MAC_SATURATE_EN: saturating accumulators plus a per-lane sat_flag.
module spmv_lane_mac
    import spmv_pkg::*;
#(
    parameter int LANES = DEF_LANES,
    parameter int DW    = DEF_DW,
    parameter int AW    = DEF_AW,
    parameter int LW    = DEF_LW
) (
    input  logic            clk,
    input  logic            rst,
    spmv_lane_mac_if.slave  bus
);

    logic [LANES-1:0]    lane_rd;
    logic [LANES-1:0]    lane_valid;
    logic [LANES-1:0]    lane_busy;
    logic [LANES*AW-1:0] res_pack;
    logic                start_go;
`ifdef SPMV_MAC_SATURATE_EN
    logic [LANES-1:0]    lane_sat;
`endif

    // A start seen while any lane is still active is dropped for every lane.
    assign start_go = bus.start && !(|lane_busy);

    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
            spmv_mac_lane #(
                .DW (DW),
                .AW (AW),
                .LW (LW)
            ) u_lane (
                .clk          (clk),
                .rst          (rst),
                .start_go     (start_go),
                .row_len      (bus.row_len),
                .val          (bus.val_in[lane_lsb(gi, DW) +: DW]),
                .val_empty    (bus.val_empty[gi]),
                .vec          (bus.vec_in[lane_lsb(gi, DW) +: DW]),
                .vec_empty    (bus.vec_empty[gi]),
                .rd           (lane_rd[gi]),
                .result       (res_pack[lane_lsb(gi, AW) +: AW]),
                .result_valid (lane_valid[gi]),
                .result_ready (bus.result_ready[gi]),
`ifdef SPMV_MAC_SATURATE_EN
                .sat_flag     (lane_sat[gi]),
`endif
                .busy         (lane_busy[gi])
            );
        end
    endgenerate

    // Value and operand FIFOs of a lane are always popped together.
    assign bus.val_read     = lane_rd;
    assign bus.vec_read     = lane_rd;
    assign bus.result       = res_pack;
    assign bus.result_valid = lane_valid;
    assign bus.busy         = |lane_busy;
`ifdef SPMV_MAC_SATURATE_EN
    assign bus.sat_flag     = lane_sat;
`endif

endmodule
